// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported synchronous memory between the instruction-fetch
// port (read-only) and the data-memory port (read/write with byte enables).
// Each access runs IDLE -> ACC -> RESP. The whole sequence takes
// MEM_LAT + 3 cycles, and the owner's done pulse arrives in RESP.
//
// Parameters
//   MEM_LAT     memory read latency, m_en cycle to valid m_rdata (1..15)
//   STARVE_MAX  consecutive data wins over a waiting fetch before fetch is
//               forced to win a conflict; 0 gives pure data priority
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   if_req/if_addr        fetch request (held until if_done) and byte address
//   if_rdata/if_done      fetched word, one-cycle completion pulse
//   if_stall              if_req & ~if_done
//   d_req/d_we/d_be       data request (held until d_done), write, byte enables
//   d_addr/d_wdata        data byte address and write data
//   d_rdata/d_done        read word, one-cycle completion pulse
//   d_stall               d_req & ~d_done
//   m_en/m_we/m_be        memory strobe (first ACC cycle only), write, enables
//   m_addr/m_wdata        word-aligned address, write data
//   m_rdata               memory read data
//
// Optional build macro ARB_PERF_EN adds perf_conflict (IDLE cycles with
// both requests pending) and perf_busy (non-IDLE cycles). Both are 32-bit
// wrapping counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | sample requests, pick the winner, latch its access
// ACC   | drive the latched access; count down the memory latency
// RESP  | owner's done pulse for one cycle, then back to IDLE

module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        m_en,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0] perf_conflict,
  output logic [31:0] perf_busy
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } stateT;

  localparam logic [3:0]  CNT_INIT  = 4'(MEM_LAT);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  stateT       state;
  stateT       nextState;

  logic        ownerData;
  logic [31:0] latAddr;
  logic        latWe;
  logic [3:0]  latBe;
  logic [31:0] latWdata;
  logic [3:0]  cnt;
  logic [7:0]  starveCnt;
  logic [31:0] ifRdataQ;
  logic [31:0] dRdataQ;

  logic        starveHit;
  logic        grantData;
  logic        anyReq;

  // Fetch only overrides data priority once it has lost STARVE_MAX
  // conflicts in a row.
  assign starveHit = (STARVE_MAX != 0) && (32'(starveCnt) == STARVE_MAX);
  assign grantData = d_req & ~(if_req & starveHit);
  assign anyReq    = if_req | d_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_be      = 4'b0000;
    m_addr    = 32'd0;
    m_wdata   = 32'd0;
    if_done   = 1'b0;
    d_done    = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) nextState = ACC;
      end
      ACC: begin
        // The counter still holds its load value only in the first ACC cycle.
        m_en    = (cnt == CNT_INIT);
        m_we    = latWe;
        m_be    = latBe;
        m_addr  = latAddr;
        m_wdata = latWdata;
        if (cnt == 4'd0) nextState = RESP;
      end
      RESP: begin
        if_done   = ~ownerData;
        d_done    = ownerData;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Stall is gated by reset so that every output reads 0 while reset is held.
    if_stall = if_req & ~if_done & ~reset;
    d_stall  = d_req & ~d_done & ~reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ownerData <= 1'b0;
      latAddr   <= 32'd0;
      latWe     <= 1'b0;
      latBe     <= 4'b0000;
      latWdata  <= 32'd0;
      cnt       <= 4'd0;
      starveCnt <= 8'd0;
      ifRdataQ  <= 32'd0;
      dRdataQ   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            ownerData <= grantData;
            cnt       <= CNT_INIT;
            if (grantData) begin
              latAddr  <= d_addr & WORD_MASK;
              latWe    <= d_we;
              latBe    <= d_we ? d_be : 4'b1111;
              latWdata <= d_wdata;
              if (if_req && (starveCnt != 8'hFF)) starveCnt <= starveCnt + 8'd1;
            end else begin
              latAddr   <= if_addr & WORD_MASK;
              latWe     <= 1'b0;
              latBe     <= 4'b1111;
              latWdata  <= 32'd0;
              starveCnt <= 8'd0;
            end
          end
        end
        ACC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (ownerData) begin
            // On a write, d_rdata keeps the last read value.
            if (!latWe) dRdataQ <= m_rdata;
          end else begin
            ifRdataQ <= m_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_rdata = ifRdataQ;
  assign d_rdata  = dRdataQ;

`ifdef ARB_PERF_EN
  logic [31:0] perfConflictQ;
  logic [31:0] perfBusyQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perfConflictQ <= 32'd0;
      perfBusyQ     <= 32'd0;
    end else begin
      if ((state == IDLE) && if_req && d_req) perfConflictQ <= perfConflictQ + 32'd1;
      if (state != IDLE) perfBusyQ <= perfBusyQ + 32'd1;
    end
  end

  assign perf_conflict = perfConflictQ;
  assign perf_busy     = perfBusyQ;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=2).
// The stimulus pushes the expected memory strobes and done responses into
// queues, tagged with their cycle numbers. A negedge monitor pops those
// queues and compares them against the DUT outputs.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        m_en;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
`ifdef ARB_PERF_EN
  logic [31:0] perf_conflict;
  logic [31:0] perf_busy;
`endif

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef ARB_PERF_EN
    , .perf_conflict(perf_conflict), .perf_busy(perf_busy)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Memory model: writes land on the strobe edge; read data appears
  // MEM_LAT cycles after the strobe cycle and is garbage otherwise.
  logic [31:0] mem [0:255];
  logic        memLoaded = 1'b0;
  logic        rdVld  [1:MEM_LAT];
  logic [7:0]  rdIdx  [1:MEM_LAT];

  always @(posedge clk) begin
    if (!memLoaded) begin
      mem[0]    <= 32'h1122_3344;
      mem[1]    <= 32'h8C08_0000;
      mem[4]    <= 32'h1234_5678;
      memLoaded <= 1'b1;
    end else if (m_en && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem[m_addr[9:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
    end
    rdVld[1] <= m_en & ~m_we;
    rdIdx[1] <= m_addr[9:2];
    for (int s = 2; s <= MEM_LAT; s++) begin
      rdVld[s] <= rdVld[s-1];
      rdIdx[s] <= rdIdx[s-1];
    end
  end

  assign m_rdata = (rdVld[MEM_LAT] === 1'b1) ? mem[rdIdx[MEM_LAT]] : 32'hDEAD_BEEF;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } memExpT;

  typedef struct {
    int          cyc;
    logic        isData;
    logic [31:0] rdata;
  } respExpT;

  memExpT  memQ[$];
  respExpT respQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushMem(input int c, input logic [31:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
    memExpT e;
    e.cyc = c; e.addr = a; e.we = we; e.be = be; e.wdata = wd;
    memQ.push_back(e);
  endtask

  task automatic pushResp(input int c, input logic isData, input logic [31:0] rd);
    respExpT e;
    e.cyc = c; e.isData = isData; e.rdata = rd;
    respQ.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 of cycle n.
  task automatic toCycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " m_en"},     32'(m_en),     32'd0);
    check({tag, " m_we"},     32'(m_we),     32'd0);
    check({tag, " m_be"},     32'(m_be),     32'd0);
    check({tag, " m_addr"},   m_addr,        32'd0);
    check({tag, " m_wdata"},  m_wdata,       32'd0);
    check({tag, " if_done"},  32'(if_done),  32'd0);
    check({tag, " d_done"},   32'(d_done),   32'd0);
    check({tag, " if_rdata"}, if_rdata,      32'd0);
    check({tag, " d_rdata"},  d_rdata,       32'd0);
    check({tag, " if_stall"}, 32'(if_stall), 32'd0);
    check({tag, " d_stall"},  32'(d_stall),  32'd0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      logic expMEn, expI, expD;
      expMEn = (memQ.size() > 0) && (memQ[0].cyc == cyc);
      check("m_en", 32'(m_en), 32'(expMEn));
      if (expMEn) begin
        check("m_addr", m_addr, memQ[0].addr);
        check("m_we", 32'(m_we), 32'(memQ[0].we));
        check("m_be", 32'(m_be), 32'(memQ[0].be));
        if (memQ[0].we) check("m_wdata", m_wdata, memQ[0].wdata);
        void'(memQ.pop_front());
      end else if ((memQ.size() > 0) && (memQ[0].cyc < cyc)) begin
        void'(memQ.pop_front());
      end

      expI = (respQ.size() > 0) && !respQ[0].isData && (respQ[0].cyc == cyc);
      expD = (respQ.size() > 0) && respQ[0].isData && (respQ[0].cyc == cyc);
      check("if_done", 32'(if_done), 32'(expI));
      check("d_done", 32'(d_done), 32'(expD));
      check("if_stall", 32'(if_stall), 32'(if_req & ~expI));
      check("d_stall", 32'(d_stall), 32'(d_req & ~expD));
      if (expI) check("if_rdata", if_rdata, respQ[0].rdata);
      if (expD) check("d_rdata", d_rdata, respQ[0].rdata);
      if (expI || expD) void'(respQ.pop_front());
      else if ((respQ.size() > 0) && (respQ[0].cyc < cyc)) void'(respQ.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [5:0] starveOrder;
    logic       isD;
    starveOrder = 6'b011011;   // bit k = 1 -> k-th grant goes to data

    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #3;
    checkAllZero("rst_init");
    reset = 1'b0;
    @(posedge clk); #1;

    // Single fetch
    c = cyc + 2; toCycle(c);
    if_addr = 32'h0040_0006; if_req = 1'b1;
    pushMem(c + 1, 32'h0040_0004, 1'b0, 4'b1111, 32'd0);
    pushResp(c + 4, 1'b0, 32'h8C08_0000);
    toCycle(c + 5); if_req = 1'b0;

    // Conflict: data first, then fetch
    c = cyc + 1; toCycle(c);
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0010;
    pushMem(c + 1, 32'h1000_0010, 1'b0, 4'b1111, 32'd0);
    pushResp(c + 4, 1'b1, 32'h1234_5678);
    pushMem(c + 6, 32'h0040_0004, 1'b0, 4'b1111, 32'd0);
    pushResp(c + 9, 1'b0, 32'h8C08_0000);
    toCycle(c + 5); d_req = 1'b0;
    toCycle(c + 10); if_req = 1'b0;

    // Starvation: both held, grant order D D I D D I
    c = cyc + 1; toCycle(c);
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      isD = starveOrder[k];
      if (isD) begin
        pushMem(c + 5*k + 1, 32'h1000_0010, 1'b0, 4'b1111, 32'd0);
        pushResp(c + 5*k + 4, 1'b1, 32'h1234_5678);
      end else begin
        pushMem(c + 5*k + 1, 32'h0040_0004, 1'b0, 4'b1111, 32'd0);
        pushResp(c + 5*k + 4, 1'b0, 32'h8C08_0000);
      end
    end
    toCycle(c + 30); if_req = 1'b0; d_req = 1'b0;

    // Byte write: d_rdata keeps the last read value
    c = cyc + 1; toCycle(c);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 32'h1000_0003; d_wdata = 32'h0000_AB00;
    pushMem(c + 1, 32'h1000_0000, 1'b1, 4'b0010, 32'h0000_AB00);
    pushResp(c + 4, 1'b1, 32'h1234_5678);
    toCycle(c + 5); d_req = 1'b0;

    // Write with be=0 still runs and completes
    c = cyc + 1; toCycle(c);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0000; d_addr = 32'h1000_0000; d_wdata = 32'hFFFF_FFFF;
    pushMem(c + 1, 32'h1000_0000, 1'b1, 4'b0000, 32'hFFFF_FFFF);
    pushResp(c + 4, 1'b1, 32'h1234_5678);
    toCycle(c + 5); d_req = 1'b0;

    // Read back the merged word
    c = cyc + 1; toCycle(c);
    d_req = 1'b1; d_we = 1'b0; d_be = 4'b0000; d_addr = 32'h1000_0002; d_wdata = 32'd0;
    pushMem(c + 1, 32'h1000_0000, 1'b0, 4'b1111, 32'd0);
    pushResp(c + 4, 1'b1, 32'h1122_AB44);
    toCycle(c + 5); d_req = 1'b0;

    // Reset asserted during RESP of a data read
    c = cyc + 1; toCycle(c);
    d_req = 1'b1; d_addr = 32'h1000_0010;
    pushMem(c + 1, 32'h1000_0010, 1'b0, 4'b1111, 32'd0);
    toCycle(c + 4); #2;
    check("pre_rst d_done", 32'(d_done), 32'd1);
    check("pre_rst d_rdata", d_rdata, 32'h1234_5678);
    reset = 1'b1; d_req = 1'b0;
    #1;
    checkAllZero("rst_resp");
    repeat (2) @(posedge clk);
    #3; reset = 1'b0;
    @(posedge clk); #1;
    toCycle(cyc + 4);

    // Reset asserted during the second ACC cycle of a fetch
    c = cyc + 1; toCycle(c);
    if_req = 1'b1; if_addr = 32'h0040_0006;
    pushMem(c + 1, 32'h0040_0004, 1'b0, 4'b1111, 32'd0);
    toCycle(c + 2); #2;
    reset = 1'b1; if_req = 1'b0;
    #1;
    checkAllZero("rst_acc");
    @(posedge clk); #3; reset = 1'b0;
    @(posedge clk); #1;

    // Fresh fetch after reset, standard latency
    c = cyc + 2; toCycle(c);
    if_req = 1'b1; if_addr = 32'h0040_0006;
    pushMem(c + 1, 32'h0040_0004, 1'b0, 4'b1111, 32'd0);
    pushResp(c + 4, 1'b0, 32'h8C08_0000);
    toCycle(c + 5); if_req = 1'b0;

    toCycle(cyc + 6);
    check("memQ drained", 32'(memQ.size()), 32'd0);
    check("respQ drained", 32'(respQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the pipeline's instruction-fetch port (read-only) and its data-memory port (read/write, byte enables).
- Sequences each access over a fixed memory latency and returns per-requester done pulses and stall signals that the IF/ID and PC hold logic consume.
- Sits between the pipeline stages and a unified memory, replacing separate instruction and data memories.

Parameters:
- MEM_LAT, 2: memory read latency in cycles from the m_en cycle to valid m_rdata; legal range 1..15.
- STARVE_MAX, 2: consecutive data wins over a waiting fetch before fetch is forced to win; 0 = pure fixed data priority.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched word; valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- if_stall  out  1  if_req & ~if_done
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = write
- d_be  in  4  byte enables for writes
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_rdata  out  32  read word; valid while d_done=1
- d_done  out  1  one-cycle completion pulse
- d_stall  out  1  d_req & ~d_done
- m_en  out  1  memory access strobe
- m_we  out  1  memory write
- m_be  out  4  memory byte enables
- m_addr  out  32  word-aligned address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data

Behaviour:
- Reset values: all outputs 0; state IDLE; owner, counters and rdata registers 0.
- Reset asserted in any state aborts the access: m_en=0, no done pulse; the next request is served normally after reset release.
- FSM states:
  - IDLE: requests are sampled only here. If any req is high: pick winner; latch owner, addr, we, be, wdata; cnt<=MEM_LAT; go to ACC.
  - ACC: m_en=1 in the first ACC cycle only; m_* driven from latched values for the whole state; cnt decrements each cycle. At cnt==0, register m_rdata into the owner's rdata register and go to RESP.
  - RESP: owner's done=1 for exactly one cycle; then go to IDLE unconditionally.
- Latency: request seen in IDLE at cycle t; m_en at t+1; m_rdata sampled at the end of t+1+MEM_LAT; done at t+2+MEM_LAT.
- Throughput: one access per MEM_LAT+3 cycles.
- Address and byte-enable rules:
  - m_addr = {addr[31:2],2'b00}.
  - Fetch: m_we=0, m_be=4'b1111.
  - Data read: m_be=4'b1111.
  - Data write: m_be=d_be, m_wdata=d_wdata; d_rdata holds its previous value.
  - Write with be=0: the access is still performed and d_done still pulses.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting, default: data wins; starve_cnt increments (saturating) whenever data wins while if_req=1.
  - If STARVE_MAX!=0 and starve_cnt==STARVE_MAX, fetch wins the conflict.
  - starve_cnt clears whenever fetch is granted.
- A requester that drops req mid-access does not abort it; done still pulses and the requester ignores it.
- The non-owner's done stays 0 throughout the access; its stall stays high for as long as its req is high.

Optional Feature:
- Macro: ARB_PERF_EN.
- When defined, adds two output ports:
  - perf_conflict (32): counts IDLE cycles with if_req & d_req.
  - perf_busy (32): counts cycles with state!=IDLE.
- Both counters wrap at 2^32 and reset to 0.
- When not defined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset: assert reset mid-run -> all outputs 0 immediately (asynchronous); after release with if_req=d_req=0, m_en stays 0.
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x00400006 at cycle 0 -> cycle 1: m_en=1, m_addr=0x00400004, m_we=0, m_be=1111; memory drives m_rdata=0x8C080000 in cycle 3 -> cycle 4: if_done=1, if_rdata=0x8C080000; if_stall=1 in cycles 0-3, 0 in cycle 4.
- Conflict: if_req and d_req (read, 0x10000010) both rise at cycle 0 -> data access m_en at cycle 1, d_done at cycle 4; fetch m_en at cycle 6, if_done at cycle 9.
- Starvation, STARVE_MAX=2: both requests held continuously (data re-requests right after each done) -> grant order D, D, I, D, D, I.
- Byte write: d_we=1, d_be=0010, d_addr=0x10000003, d_wdata=0x0000AB00 -> m_addr=0x10000000, m_be=0010, m_we=1, m_wdata=0x0000AB00; d_done pulses; d_rdata unchanged.
- Reset in ACC: assert reset during the second ACC cycle -> m_en=0, no done pulse; after release, a new fetch completes with standard latency.
